muldiv_seq: RTL

- Iterative RV32M multiply/divide sequencer sitting beside the EX-stage ALU.
- When ALU decode flags an M-extension instruction (R-type, func7 = 0000001), EX issues `start` with func3 and both operands.
- The block stalls the pipeline while it shifts through 32 iterations, then presents one result word for one cycle.
- It owns the multi-cycle schedule; the ALU keeps single-cycle ops.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_signfix.sv | 54 +++++
 rtl/muldiv_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: func3 ops, func7 tag,
// FSM state encoding and default widths.
package muldiv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 6;

  localparam logic [6:0] FUNC7_MEXT = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling around the unsigned iterative core: operand magnitudes and the
// correction flag at issue time, final negation and word select at completion.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]        in_func3,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              neg_flag,
  input  logic [2:0]        out_func3,
  input  logic              out_neg,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   word
);

  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  always_comb begin
    a_signed = (in_func3 == F3_MUL) || (in_func3 == F3_MULH) || (in_func3 == F3_MULHSU) ||
               (in_func3 == F3_DIV) || (in_func3 == F3_REM);
    b_signed = (in_func3 == F3_MUL) || (in_func3 == F3_MULH) ||
               (in_func3 == F3_DIV) || (in_func3 == F3_REM);
    a_neg    = a_signed & rs1_data[XLEN-1];
    b_neg    = b_signed & rs2_data[XLEN-1];
    mag_a    = a_neg ? -rs1_data : rs1_data;
    mag_b    = b_neg ? -rs2_data : rs2_data;
    // Remainder follows the dividend; product and quotient follow the sign product.
    neg_flag = (in_func3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    prod = out_neg ? -acc : acc;
    quo  = acc[XLEN-1:0];
    rem  = acc[2*XLEN-1:XLEN];
    word = '0;
    case (out_func3)
      F3_MUL:                       word = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: word = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              word = out_neg ? -quo : quo;
      default:                      word = out_neg ? -rem : rem;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer with pipeline stall and flush.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy
);

  // Handshake: start is taken only in IDLE when flush is low; result is valid
  // exactly while result_valid is high (one cycle, DONE and no flush).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        func3_q, func3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   mag_a, mag_b;
  logic              neg_flag;
  logic [XLEN-1:0]   final_word;
  logic [2*XLEN-1:0] step_acc;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_sub;
  logic              div_zero;
  logic              div_ovf;

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .in_func3  (func3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .neg_flag  (neg_flag),
    .out_func3 (func3_q),
    .out_neg   (neg_q),
    .acc       (step_acc),
    .word      (final_word)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a;
  logic signed [XLEN:0]     fast_b;
  logic signed [2*XLEN-1:0] fast_p;
  logic [XLEN-1:0]          fast_word;

  always_comb begin
    fast_a    = {(func3 != F3_MULHU) & rs1_data[XLEN-1], rs1_data};
    fast_b    = {~func3[1] & rs2_data[XLEN-1], rs2_data};
    fast_p    = fast_a * fast_b;
    fast_word = (func3 == F3_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  end
`endif

  // One iteration of either engine, evaluated from the current accumulator.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_sub = XLEN'(rem_sh - {1'b0, opnd_q});
    if (func3_q[2]) begin
      if (rem_sh >= {1'b0, opnd_q}) step_acc = {rem_sub, acc_q[XLEN-2:0], 1'b1};
      else                          step_acc = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      step_acc = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    div_zero = (rs2_data == '0);
    div_ovf  = ~func3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    func3_d  = func3_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          func3_d = func3;
          neg_d   = neg_flag;
          if (func3[2] && div_zero) begin
            state_d  = ST_DONE;
            result_d = func3[1] ? rs1_data : '1;
          end else if (func3[2] && div_ovf) begin
            state_d  = ST_DONE;
            result_d = func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
          end else if (!func3[2]) begin
            state_d  = ST_DONE;
            result_d = fast_word;
`endif
          end else begin
            state_d = ST_BUSY;
            cnt_d   = '0;
            // Multiply adds the multiplicand into the high half; divide shifts the dividend out.
            opnd_d  = func3[2] ? mag_b : mag_a;
            acc_d   = {{XLEN{1'b0}}, (func3[2] ? mag_a : mag_b)};
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = step_acc;
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          result_d = final_word;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      func3_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      func3_q  <= func3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign stall        = ((state_q == ST_IDLE) && start && !flush) || (state_q == ST_BUSY);
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE) && !flush;
  assign result       = result_q;

endmodule
